// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and constants for the SPI/host RAM arbiter.
package spi_ram_arbiter_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RDATA
  } arb_state_e;

  typedef enum logic {
    GNT_SPI,
    GNT_HOST
  } grant_e;

  // Pending SPI data operation: read flag plus command payload
  typedef struct packed {
    logic              rd;
    logic [DATA_W-1:0] payload;
  } spi_op_t;

endpackage

// File: rtl/spi_ram_arbiter_cmd_capture.sv
// SPI command capture: rx_valid edge detect, address registers, pending data op, overrun flag.
module spi_cmd_capture
  import spi_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_W-1:0]      rx_data,
  input  logic                  rx_valid,
  input  logic                  spi_clr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  spi_pend,
  output spi_op_t               spi_op,
  output logic                  spi_overrun,
  output logic                  capture_c
);

  logic       rx_valid_d;
  logic [1:0] opcode;

  assign opcode    = rx_data[CMD_W-1:CMD_W-2];
  assign capture_c = rx_valid & ~rx_valid_d;

  // Decode each new word; a fresh capture takes priority over the arbiter's clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      spi_pend    <= 1'b0;
      spi_op      <= '0;
      spi_overrun <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      if (spi_clr) spi_pend <= 1'b0;
      if (capture_c) begin
        if (spi_pend) spi_overrun <= 1'b1;
        case (opcode)
          CMD_WR_ADDR: wr_addr <= rx_data[ADDR_WIDTH-1:0];
          CMD_RD_ADDR: rd_addr <= rx_data[ADDR_WIDTH-1:0];
          default: begin
            spi_pend       <= 1'b1;
            spi_op.rd      <= (opcode == CMD_RD_DATA);
            spi_op.payload <= rx_data[DATA_W-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the SPI command path and a host port.
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_W-1:0]      rx_data,
  input  logic                  rx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_W-1:0]     host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  spi_overrun
);

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  spi_pend;
  spi_op_t               spi_op;
  logic                  capture_c;
  logic                  spi_clr_c;
  logic                  spi_win_c;

  arb_state_e            state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  mem_en_d, mem_we_d, host_gnt_d, host_rvalid_d, tx_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_d, host_rdata_d, tx_data_d;

  spi_cmd_capture #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmd (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .spi_clr     (spi_clr_c),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .spi_pend    (spi_pend),
    .spi_op      (spi_op),
    .spi_overrun (spi_overrun),
    .capture_c   (capture_c)
  );

  // SPI wins when alone or when the host was served last
  assign spi_win_c = spi_pend && (!host_req || (last_grant_q == GNT_HOST));

  // Next state and next registered outputs
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    spi_clr_c     = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata;
    tx_data_d     = tx_data;
    tx_valid_d    = tx_valid;
    case (state_q)
      ARB_IDLE: begin
        if (spi_pend || host_req) begin
          state_d  = ARB_ACCESS;
          mem_en_d = 1'b1;
          if (spi_win_c) begin
            last_grant_d = GNT_SPI;
            spi_clr_c    = 1'b1;
            mem_we_d     = ~spi_op.rd;
            mem_addr_d   = spi_op.rd ? rd_addr : wr_addr;
            mem_wdata_d  = spi_op.payload;
          end else begin
            last_grant_d = GNT_HOST;
            host_gnt_d   = 1'b1;
            mem_we_d     = host_we;
            mem_addr_d   = host_addr;
            mem_wdata_d  = host_wdata;
          end
        end
      end
      ARB_ACCESS: state_d = mem_we ? ARB_IDLE : ARB_RDATA;
      ARB_RDATA: begin
        state_d = ARB_IDLE;
        if (last_grant_q == GNT_SPI) begin
          tx_data_d  = mem_rdata;
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = mem_rdata;
          host_rvalid_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // A new SPI word makes any previous read response stale
    if (capture_c) tx_valid_d = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_HOST;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      host_gnt     <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_en       <= mem_en_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      host_gnt     <= host_gnt_d;
      host_rvalid  <= host_rvalid_d;
      host_rdata   <= host_rdata_d;
      tx_data      <= tx_data_d;
      tx_valid     <= tx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: SPI vector table, contention, overrun and reset sequences.
module tb_spi_ram_arbiter;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst_n;
  logic [9:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [7:0]    host_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          spi_overrun;

  spi_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .spi_overrun (spi_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM model
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic       host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } sb_t;

  typedef struct packed {
    logic       host;
    logic [7:0] data;
  } rd_t;

  typedef struct packed {
    logic [9:0] word;
    logic       op;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  sb_t  sb_q [$];
  rd_t  rd_q [$];
  vec_t vt [12];
  int   n_vec;
  int   n_err;

  function automatic sb_t mk(input logic h, input logic w, input logic [7:0] a,
                             input logic [7:0] wd, input logic [7:0] rd);
    sb_t e;
    e.host = h; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops expected RAM accesses and read responses as the DUT produces them
  task automatic monitor();
    logic prev_tx;
    sb_t  e;
    rd_t  r;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_mem: addr %0h we %0b wdata %0h, none expected", mem_addr, mem_we, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          check("mem_owner_gnt", 32'(host_gnt), 32'(e.host));
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          else begin
            r.host = e.host; r.data = e.rdata;
            rd_q.push_back(r);
          end
        end
      end
      if ((tx_valid && !prev_tx) || host_rvalid) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rdata: tx_valid %0b host_rvalid %0b, none expected", tx_valid, host_rvalid);
        end else begin
          r = rd_q.pop_front();
          if (host_rvalid) check("host_rdata", 32'({1'b1, host_rdata}), 32'({r.host, r.data}));
          else             check("tx_data", 32'({1'b0, tx_data}), 32'({r.host, r.data}));
        end
      end
      prev_tx = tx_valid;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
    check({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
    check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_overrun"}, 32'(spi_overrun), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic spi_word(input logic [9:0] w);
    rx_data = w; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (6) step();
  endtask

  // SPI data word captured at E, host request raised at E+1 so both contend in the same idle cycle
  task automatic contend(input logic [9:0] w, input logic hwe, input logic [7:0] ha,
                         input logic [7:0] hd, input int dly);
    logic got;
    rx_data = w; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = hwe; host_addr = ha; host_wdata = hd;
    got = 1'b0;
    for (int k = 1; k <= 12 && !got; k++) begin
      step();
      if (host_gnt) begin
        got = 1'b1;
        check("gnt_latency", 32'(k), 32'(dly));
        host_req = 1'b0;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL gnt_timeout: no host_gnt within 12 cycles, required after %0d", dly);
      host_req = 1'b0;
    end
    repeat (6) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b1; rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    vt[0]  = '{10'h005, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[1]  = '{10'h1A5, 1'b1, 1'b1, 8'h05, 8'hA5, 8'h00};
    vt[2]  = '{10'h205, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[3]  = '{10'h300, 1'b1, 1'b0, 8'h05, 8'h00, 8'hA5};
    vt[4]  = '{10'h010, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[5]  = '{10'h15A, 1'b1, 1'b1, 8'h10, 8'h5A, 8'h00};
    vt[6]  = '{10'h210, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[7]  = '{10'h3FF, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
    vt[8]  = '{10'h0FF, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[9]  = '{10'h100, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00};
    vt[10] = '{10'h2FF, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[11] = '{10'h3C3, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};

    #2 rst_n = 1'b0;
    fork
      monitor();
    join_none
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // SPI command table: RAM strobe at E+2, read data at E+4, tx_valid cleared by each new word
    for (int i = 0; i < 12; i++) begin
      rx_data = vt[i].word; rx_valid = 1'b1;
      if (vt[i].op) sb_q.push_back(mk(1'b0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata));
      step();
      rx_valid = 1'b0;
      check("tx_clr_on_word", 32'(tx_valid), 32'd0);
      step();
      check("mem_en_at_e2", 32'(mem_en), 32'(vt[i].op));
      step(); step();
      if (vt[i].op && !vt[i].we) begin
        check("tx_valid_at_e4", 32'(tx_valid), 32'd1);
        check("tx_data_at_e4", 32'(tx_data), 32'(vt[i].rdata));
      end
      step();
    end

    // Contention from reset: SPI first, then strict alternation
    do_reset();
    spi_word(10'h020);
    sb_q.push_back(mk(1'b0, 1'b1, 8'h20, 8'h77, 8'h00));
    sb_q.push_back(mk(1'b1, 1'b1, 8'h10, 8'h3C, 8'h00));
    contend(10'h177, 1'b1, 8'h10, 8'h3C, 3);
    spi_word(10'h220);
    sb_q.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00, 8'h77));
    sb_q.push_back(mk(1'b1, 1'b1, 8'h11, 8'h5A, 8'h00));
    contend(10'h300, 1'b1, 8'h11, 8'h5A, 4);
    sb_q.push_back(mk(1'b0, 1'b1, 8'h20, 8'h55, 8'h00));
    spi_word(10'h155);
    sb_q.push_back(mk(1'b1, 1'b0, 8'h11, 8'h00, 8'h5A));
    sb_q.push_back(mk(1'b0, 1'b1, 8'h20, 8'h66, 8'h00));
    contend(10'h166, 1'b0, 8'h11, 8'h00, 1);

    // Host read: grant at N+1, rvalid pulse at N+3, data held afterwards
    sb_q.push_back(mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C));
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    step();
    check("hrd_gnt_n1", 32'(host_gnt), 32'd1);
    check("hrd_mem_en_n1", 32'(mem_en), 32'd1);
    host_req = 1'b0;
    step();
    check("hrd_rvalid_n2", 32'(host_rvalid), 32'd0);
    step();
    check("hrd_rvalid_n3", 32'(host_rvalid), 32'd1);
    check("hrd_rdata_n3", 32'(host_rdata), 32'h3C);
    step();
    check("hrd_rvalid_n4", 32'(host_rvalid), 32'd0);
    check("hrd_rdata_hold", 32'(host_rdata), 32'h3C);
    step();

    // Overrun: two SPI data words while the host read occupies the RAM
    spi_word(10'h030);
    check("ovr_before", 32'(spi_overrun), 32'd0);
    sb_q.push_back(mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C));
    sb_q.push_back(mk(1'b0, 1'b1, 8'h30, 8'h22, 8'h00));
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    rx_data = 10'h111; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("ovr_host_gnt", 32'(host_gnt), 32'd1);
    check("ovr_first_word", 32'(spi_overrun), 32'd0);
    host_req = 1'b0;
    step();
    rx_data = 10'h122; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("ovr_set", 32'(spi_overrun), 32'd1);
    step();
    check("ovr_second_exec", 32'(mem_en), 32'd1);
    repeat (4) step();
    check("ovr_sticky", 32'(spi_overrun), 32'd1);

    // Reset during the read-data cycle discards the read
    spi_word(10'h230);
    sb_q.push_back(mk(1'b0, 1'b0, 8'h30, 8'h00, 8'h22));
    rx_data = 10'h300; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    check("rst_rd_mem_en", 32'(mem_en), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    rd_q.delete();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    sb_q.push_back(mk(1'b0, 1'b1, 8'h00, 8'h99, 8'h00));
    sb_q.push_back(mk(1'b1, 1'b1, 8'h12, 8'h44, 8'h00));
    contend(10'h199, 1'b1, 8'h12, 8'h44, 3);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("rd_drained", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Shares one single-port synchronous RAM between the SPI slave receive/transmit path and a parallel host port. Decodes 10-bit SPI command words into write-address, write-data, read-address and read-data operations, holds the latched SPI addresses, and grants RAM access round-robin between SPI and host. Sits between the SPI slave and the RAM in the SPI wrapper, replacing direct slave-to-RAM coupling.

## Interface
- ADDR_WIDTH, 8: RAM address width; SPI addresses use rx_data[ADDR_WIDTH-1:0], ADDR_WIDTH ≤ 8
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  10  SPI command word; [9:8] opcode, [7:0] payload
- rx_valid  in  1  level from slave; a rising edge marks a new word
- tx_data  out  8  read data to slave
- tx_valid  out  1  tx_data valid, held (see Operation)
- host_req  in  1  host request; held with fields until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  8  host write data
- host_gnt  out  1  one-cycle accept pulse
- host_rvalid  out  1  one-cycle read-data-valid pulse
- host_rdata  out  8  read data, held until next host read
- mem_en  out  1  RAM access strobe, one cycle per access
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid the cycle after mem_en with mem_we=0
- spi_overrun  out  1  sticky: new SPI word arrived while previous RAM op still pending

## Operation
- Reset: every output 0; wr_addr, rd_addr = 0; state ARB_IDLE; last_grant = HOST (SPI wins first tie); no pending op.
- Edge detect: rx_valid_d registered; capture cycle E is when rx_valid=1 and rx_valid_d=0.
- Opcode 00: wr_addr ← payload at end of E. No RAM access.
- Opcode 10: rd_addr ← payload at end of E. No RAM access.
- Opcode 01 (write data) / 11 (read data): set spi_pend with opcode and payload at end of E; visible from E+1.
- Capture with spi_pend already set: new op overwrites pending op, spi_overrun ← 1 (cleared only by reset).
- Any capture clears tx_valid at end of E.
- FSM, states ARB_IDLE, ARB_ACCESS, ARB_RDATA:
  - ARB_IDLE: if spi_pend or host_req, pick winner (both → opposite of last_grant), register mem_addr/mem_we/mem_wdata, update last_grant, clear spi_pend if SPI wins → ARB_ACCESS.
  - ARB_ACCESS: mem_en=1; host_gnt=1 if host won → ARB_RDATA if read, else ARB_IDLE.
  - ARB_RDATA: capture mem_rdata; SPI → tx_data, tx_valid ← 1; host → host_rdata, host_rvalid pulse → ARB_IDLE.
- SPI write uses wr_addr and payload; SPI read uses rd_addr (payload ignored).
- tx_valid stays 1 until next capture or reset.
- Address regs updated during an in-flight SPI access affect only later ops (address registered in ARB_IDLE).

## Timing
- Request first visible in ARB_IDLE at cycle N → mem_en and host_gnt at N+1; write complete at N+1.
- Read: mem_rdata sampled end of N+2; tx_valid/host_rvalid high at N+3.
- SPI data op: capture E, mem_en at E+2 earliest, tx_valid at E+4 earliest.
- Back-to-back: writes every 2 cycles, reads every 3 cycles.
- Max wait under contention: one competing access (≤3 cycles) before grant.
- Reset asserted mid-access: outputs drop immediately; in-flight read discarded, no rvalid/tx_valid.

## Structure
- Package spi_ram_arbiter_pkg: arb_state_e {ARB_IDLE, ARB_ACCESS, ARB_RDATA}; opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11; grant enum {GNT_SPI, GNT_HOST}.
- One sub-module: spi_cmd_capture (edge detect, address regs, spi_pend, overrun).

## Test plan
- SPI 0x005, then 0x1A5 → mem_en, mem_we=1, mem_addr=0x05, mem_wdata=0xA5 at E+2 of second word.
- SPI 0x205, then 0x300 with RAM[5]=0xA5 → mem_addr=0x05 read, tx_valid=1, tx_data=0xA5 at E+4; cleared on next word.
- host_req write addr 0x10 data 0x3C in same cycle SPI write pending → SPI granted first, host_gnt two cycles later; then roles alternate over 4 contended requests.
- Host read addr 0x10 → host_gnt at N+1, host_rvalid pulse with host_rdata=0x3C at N+3.
- Two SPI data words while host holds bus → spi_overrun=1, only second word executed.
- rst_n low during ARB_RDATA → all outputs 0 at once, no tx_valid afterward, next SPI op wins tie.
